// File: rtl/data_deshuffler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_deshuffler                                              |
// | Description : Collects SpatPar row beats into one tile word, optionally    |
// |               transposes it per element, and presents it on a registered   |
// |               valid-ready port toward the wide write streamer.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_deshuffler #(
  parameter int unsigned SpatPar   = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Elems     = DataWidth / SpatPar
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DataWidth-1:0]         a_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  output logic [SpatPar*DataWidth-1:0] z_o,
  output logic                         z_valid_o,
  input  logic                         z_ready_i,
  input  logic [31:0]                  csr_en_transpose_i,
  input  logic                         csr_valid_i,
  output logic                         csr_ready_o,
  output logic [31:0]                  tile_cnt_o
);

  localparam int unsigned        c_cnt_w     = (SpatPar > 1) ? $clog2(SpatPar) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(SpatPar - 1);

  logic [c_cnt_w-1:0]                  r_beat_cnt;
  logic [SpatPar-2:0][DataWidth-1:0]   r_rows;
  logic                                r_transpose;
  logic [SpatPar*DataWidth-1:0]        r_z;
  logic                                r_z_valid;
  logic [31:0]                         r_tile_cnt;

  logic                                w_last;
  logic                                w_a_ready;
  logic                                w_a_fire;
  logic                                w_z_fire;
  logic                                w_csr_ready;
  logic                                w_csr_fire;
  logic [SpatPar-1:0][DataWidth-1:0]   w_rows;
  logic [SpatPar*DataWidth-1:0]        w_tile;
  logic                                w_unused_csr;

  assign w_last      = (r_beat_cnt == c_last_beat);
  assign w_a_ready   = !(w_last && r_z_valid && !z_ready_i);
  assign w_a_fire    = a_valid_i && w_a_ready;
  assign w_z_fire    = r_z_valid && z_ready_i;
  assign w_csr_ready = (r_beat_cnt == '0);
  assign w_csr_fire  = csr_valid_i && w_csr_ready;

  assign w_unused_csr = ^csr_en_transpose_i[31:1];

  // The incoming beat is the final row; no need to buffer it.
  assign w_rows[SpatPar-1]   = a_i;
  assign w_rows[SpatPar-2:0] = r_rows;

  for (genvar i = 0; i < SpatPar; i++) begin : g_row
    for (genvar j = 0; j < SpatPar; j++) begin : g_col
      assign w_tile[(i*SpatPar+j)*Elems +: Elems] =
          r_transpose ? w_rows[j][i*Elems +: Elems] : w_rows[i][j*Elems +: Elems];
    end
  end

  for (genvar k = 0; k < SpatPar - 1; k++) begin : g_buf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rows[k] <= '0;
      end else if (w_a_fire && (r_beat_cnt == c_cnt_w'(k))) begin
        r_rows[k] <= a_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat_cnt <= '0;
    end else if (w_a_fire) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + c_cnt_w'(1);
    end
  end

  // A new tile takes priority over clearing, giving bubble-free back-to-back words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
    end else if (w_a_fire && w_last) begin
      r_z       <= w_tile;
      r_z_valid <= 1'b1;
    end else if (w_z_fire) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_transpose <= 1'b0;
      r_tile_cnt  <= '0;
    end else if (w_csr_fire) begin
      r_transpose <= csr_en_transpose_i[0];
      r_tile_cnt  <= '0;
    end else if (w_z_fire) begin
      r_tile_cnt  <= r_tile_cnt + 32'd1;
    end
  end

  assign a_ready_o   = w_a_ready;
  assign csr_ready_o = w_csr_ready;
  assign z_o         = r_z;
  assign z_valid_o   = r_z_valid;
  assign tile_cnt_o  = r_tile_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_deshuffler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_deshuffler                                           |
// | Description : Directed and randomized self-checking bench for the tile     |
// |               deshuffler against a queue-based tile model.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_deshuffler;

  localparam int SP = 8;
  localparam int DW = 64;
  localparam int EW = 8;
  localparam int ZW = SP * DW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] a_i = '0;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [ZW-1:0] z_o;
  logic          z_valid_o;
  logic          z_ready_i = 1'b0;
  logic [31:0]   csr_en_transpose_i = '0;
  logic          csr_valid_i = 1'b0;
  logic          csr_ready_o;
  logic [31:0]   tile_cnt_o;

  always #5 clk_i = ~clk_i;

  data_deshuffler #(.SpatPar(SP), .DataWidth(DW), .Elems(EW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .a_i                (a_i),
    .a_valid_i          (a_valid_i),
    .a_ready_o          (a_ready_o),
    .z_o                (z_o),
    .z_valid_o          (z_valid_o),
    .z_ready_i          (z_ready_i),
    .csr_en_transpose_i (csr_en_transpose_i),
    .csr_valid_i        (csr_valid_i),
    .csr_ready_o        (csr_ready_o),
    .tile_cnt_o         (tile_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: collected beats, pending word, config and counter.
  logic [DW-1:0] m_beats[$];
  bit            m_tr;
  logic [ZW-1:0] m_z;
  bit            m_zv;
  logic [31:0]   m_cnt;

  task automatic check(input string tag, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ZW-1:0] build_tile(input bit tr);
    logic [ZW-1:0] t;
    logic [DW-1:0] row;
    t = '0;
    for (int i = 0; i < SP; i++) begin
      for (int j = 0; j < SP; j++) begin
        row = tr ? m_beats[j] : m_beats[i];
        t[(i*SP+j)*EW +: EW] = tr ? row[i*EW +: EW] : row[j*EW +: EW];
      end
    end
    return t;
  endfunction

  function automatic logic [DW-1:0] byte_fill(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {8{b}};
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_tr  = 1'b0;
    m_z   = '0;
    m_zv  = 1'b0;
    m_cnt = '0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit av, input logic [DW-1:0] a, input bit zr,
                      input bit cv, input logic [31:0] cdat);
    bit exp_ar, exp_cr, a_fire, z_fire, c_fire, new_tile;
    a_valid_i = av; a_i = a; z_ready_i = zr; csr_valid_i = cv; csr_en_transpose_i = cdat;
    #1;
    exp_ar = !((m_beats.size() == SP - 1) && m_zv && !zr);
    exp_cr = (m_beats.size() == 0);
    check("a_ready", a_ready_o, exp_ar);
    check("csr_ready", csr_ready_o, exp_cr);
    check("z_valid", z_valid_o, m_zv);
    check("z_word", z_o, m_z);
    check("tile_cnt", tile_cnt_o, m_cnt);
    a_fire = av && exp_ar;
    z_fire = m_zv && zr;
    c_fire = cv && exp_cr;
    new_tile = 1'b0;
    if (a_fire) begin
      m_beats.push_back(a);
      if (m_beats.size() == SP) begin
        m_z = build_tile(m_tr);
        m_zv = 1'b1;
        new_tile = 1'b1;
        m_beats.delete();
      end
    end
    if (z_fire && !new_tile) begin
      m_z = '0;
      m_zv = 1'b0;
    end
    if (c_fire) begin
      m_tr = cdat[0];
      m_cnt = '0;
    end else if (z_fire) begin
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    a_valid_i = 1'b0; csr_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_z_valid", z_valid_o, 1'b0);
    check("rst_z", z_o, '0);
    check("rst_tile_cnt", tile_cnt_o, '0);
    check("rst_a_ready", a_ready_o, 1'b1);
    check("rst_csr_ready", csr_ready_o, 1'b1);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  logic [ZW-1:0] exp_w;
  logic [DW-1:0] saved15;

  initial begin
    model_reset();
    @(posedge clk_i);
    #1;
    apply_reset();

    // No transpose: rows of repeated bytes
    step(0, '0, 1, 1, 32'h0);
    for (int k = 0; k < SP; k++) step(1, byte_fill(k), 1, 0, '0);
    for (int i = 0; i < SP; i++) exp_w[i*DW +: DW] = byte_fill(i);
    check("t1_valid", z_valid_o, 1'b1);
    check("t1_word", z_o, exp_w);
    step(0, '0, 1, 0, '0);
    check("t1_cnt", tile_cnt_o, 32'd1);

    // Transpose: every row reads 0x0706050403020100
    step(0, '0, 1, 1, 32'hFFFF_FFFF);
    for (int k = 0; k < SP; k++) step(1, byte_fill(k), 0, 0, '0);
    for (int i = 0; i < SP; i++) exp_w[i*DW +: DW] = 64'h0706050403020100;
    check("t2_word", z_o, exp_w);
    step(0, '0, 1, 0, '0);

    // Backpressure: second tile's last beat stalls until the word is taken
    step(0, '0, 0, 1, 32'h2);
    for (int k = 0; k < 2 * SP; k++) begin
      saved15 = {$urandom, $urandom};
      step(1, saved15, 0, 0, '0);
    end
    check("t3_stall", a_ready_o, 1'b0);
    check("t3_hold", z_o, m_z);
    step(1, saved15, 1, 0, '0);
    check("t3_b2b_valid", z_valid_o, 1'b1);
    check("t3_cnt", tile_cnt_o, 32'd1);
    step(0, '0, 1, 0, '0);

    // Back-to-back: 64 beats, no idle on a_ready
    step(0, '0, 1, 1, 32'h0);
    for (int k = 0; k < 8 * SP; k++) step(1, {$urandom, $urandom}, 1, 0, '0);
    step(0, '0, 1, 0, '0);
    check("t4_cnt", tile_cnt_o, 32'd8);

    // CSR gating mid-tile, then write colliding with z_fire
    for (int k = 0; k < 3; k++) step(1, {$urandom, $urandom}, 1, 0, '0);
    step(0, '0, 1, 1, 32'h1);
    for (int k = 3; k < SP; k++) step(1, byte_fill(k), 1, 0, '0);
    step(0, '0, 1, 1, 32'h1);
    check("t5_clear_wins", tile_cnt_o, 32'd0);

    // Reset mid-tile, then a clean untransposed tile
    for (int k = 0; k < 5; k++) step(1, {$urandom, $urandom}, 1, 0, '0);
    apply_reset();
    for (int k = 0; k < SP; k++) step(1, byte_fill(k + 16), 0, 0, '0);
    for (int i = 0; i < SP; i++) exp_w[i*DW +: DW] = byte_fill(i + 16);
    check("t6_word", z_o, exp_w);
    step(0, '0, 1, 0, '0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 3) apply_reset();
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
